// File: rtl/switch_debounce_if.sv
// Raw front-panel switch inputs and their conditioned outputs.
// master drives the pads; slave is the debouncer.
interface switch_debounce_if;
   logic       i_switch_1_raw;
   logic       i_switch_2_raw;
   logic       o_switch_1;
   logic       o_switch_2;
   logic [1:0] o_select;
   logic       o_change;

   modport master (
      output i_switch_1_raw,
      output i_switch_2_raw,
      input  o_switch_1,
      input  o_switch_2,
      input  o_select,
      input  o_change
   );

   modport slave (
      input  i_switch_1_raw,
      input  i_switch_2_raw,
      output o_switch_1,
      output o_switch_2,
      output o_select,
      output o_change
   );
endinterface

// File: rtl/switch_debounce.sv
// Two-channel switch conditioner: 2-flop synchronizer plus hold-time debounce per channel,
// with a one-cycle strobe whenever either debounced level changes.
module switch_debounce #(
   parameter int unsigned c_DEBOUNCE_CNT = 1108422,
   parameter int unsigned c_CNT_WIDTH    = 21
) (
   input  logic             i_clock,
   input  logic             i_reset,
   switch_debounce_if.slave sw
);

   localparam logic [c_CNT_WIDTH-1:0] Terminal = c_CNT_WIDTH'(c_DEBOUNCE_CNT - 1);

   if (c_DEBOUNCE_CNT == 0 ||
       64'(c_DEBOUNCE_CNT) > ((64'(1) << c_CNT_WIDTH) - 64'(1))) begin : g_bad_cfg
      $error("switch_debounce: c_DEBOUNCE_CNT does not fit in c_CNT_WIDTH bits");
   end

   typedef enum logic {
      StStable,
      StChanging
   } state_e;

   logic [1:0]             raw;
   logic [1:0]             meta_q;
   logic [1:0]             sync_q;
   state_e                 state_q [2];
   state_e                 state_d [2];
   logic [c_CNT_WIDTH-1:0] cnt_q   [2];
   logic [c_CNT_WIDTH-1:0] cnt_d   [2];
   logic [1:0]             level_q;
   logic [1:0]             level_d;
   logic                   change_q;
   logic                   change_d;

   // Bit 0 is switch 1, bit 1 is switch 2.
   assign raw = {sw.i_switch_2_raw, sw.i_switch_1_raw};

   always_comb begin
      level_d = level_q;
      for (int ch = 0; ch < 2; ch++) begin
         state_d[ch] = state_q[ch];
         cnt_d[ch]   = cnt_q[ch];
         unique case (state_q[ch])
            StStable: begin
               cnt_d[ch] = '0;
               if (sync_q[ch] != level_q[ch]) begin
                  state_d[ch] = StChanging;
               end
            end
            StChanging: begin
               if (sync_q[ch] == level_q[ch]) begin
                  // Input bounced back before qualifying: drop the attempt.
                  state_d[ch] = StStable;
                  cnt_d[ch]   = '0;
               end else if (cnt_q[ch] == Terminal) begin
                  level_d[ch] = sync_q[ch];
                  state_d[ch] = StStable;
                  cnt_d[ch]   = '0;
               end else begin
                  cnt_d[ch] = cnt_q[ch] + 1'b1;
               end
            end
         endcase
      end
      // One strobe even when both channels qualify on the same edge.
      change_d = |(level_d ^ level_q);
   end

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         meta_q   <= 2'b00;
         sync_q   <= 2'b00;
         level_q  <= 2'b00;
         change_q <= 1'b0;
         for (int ch = 0; ch < 2; ch++) begin
            state_q[ch] <= StStable;
            cnt_q[ch]   <= '0;
         end
      end else begin
         meta_q   <= raw;
         sync_q   <= meta_q;
         level_q  <= level_d;
         change_q <= change_d;
         for (int ch = 0; ch < 2; ch++) begin
            state_q[ch] <= state_d[ch];
            cnt_q[ch]   <= cnt_d[ch];
         end
      end
   end

   assign sw.o_switch_1 = level_q[0];
   assign sw.o_switch_2 = level_q[1];
   assign sw.o_select   = {level_q[0], level_q[1]};
   assign sw.o_change   = change_q;

endmodule

// File: tb/tb_switch_debounce.sv
// Randomised and directed bench for switch_debounce against a run-length reference model.
module tb_switch_debounce;

   localparam int unsigned N = 16;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_bad = 0;
   int   chg_cnt = 0;

   switch_debounce_if sif ();

   switch_debounce #(
      .c_DEBOUNCE_CNT(N),
      .c_CNT_WIDTH   (5)
   ) dut (
      .i_clock(clk),
      .i_reset(rst),
      .sw     (sif)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   // Reference: the synchronized value is the raw sample from two edges earlier; a level is
   // accepted once it has disagreed with the output on N+1 consecutive edges.
   logic [1:0] rq [$];
   logic [1:0] m_lvl = 2'b00;
   int         m_run [2] = '{0, 0};
   logic       m_chg = 1'b0;

   always @(posedge clk or posedge rst) begin
      logic [1:0] sv;
      logic       acc;
      if (rst) begin
         rq.delete();
         m_lvl = 2'b00;
         m_run[0] = 0;
         m_run[1] = 0;
         m_chg = 1'b0;
      end else begin
         sv  = (rq.size() >= 2) ? rq[rq.size()-2] : 2'b00;
         acc = 1'b0;
         for (int ch = 0; ch < 2; ch++) begin
            if (sv[ch] != m_lvl[ch]) begin
               m_run[ch]++;
               if (m_run[ch] == N + 1) begin
                  m_lvl[ch] = sv[ch];
                  m_run[ch] = 0;
                  acc = 1'b1;
               end
            end else begin
               m_run[ch] = 0;
            end
         end
         m_chg = acc;
         rq.push_back({sif.i_switch_2_raw, sif.i_switch_1_raw});
         if (rq.size() > 2) void'(rq.pop_front());
      end
   end

   always @(negedge clk) begin
      logic [4:0] got, exp;
      got = {sif.o_switch_1, sif.o_switch_2, sif.o_select, sif.o_change};
      exp = {m_lvl[0], m_lvl[1], m_lvl[0], m_lvl[1], m_chg};
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL per_cycle t=%0t got %b expected %b", $time, got, exp);
      end
      if (sif.o_change === 1'b1) chg_cnt++;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic wait_sel(input logic [1:0] want, input int limit, output int e);
      e = -1;
      for (int i = 0; i < limit; i++) begin
         @(posedge clk);
         #1;
         if (sif.o_select === want) begin
            e = cyc;
            break;
         end
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   int s, e;
   int hold [2];

   initial begin
      sif.i_switch_1_raw = 1'b0;
      sif.i_switch_2_raw = 1'b0;
      rst = 1'b1;
      idle(3);
      check("reset_outputs", {27'd0, sif.o_switch_1, sif.o_switch_2, sif.o_select, sif.o_change},
            32'd0);
      rst = 1'b0;
      idle(3);

      // Clean press and release on switch 1.
      sif.i_switch_1_raw = 1'b1;
      s = cyc + 1;
      chg_cnt = 0;
      wait_sel(2'b10, 40, e);
      check("press_edge", e, s + 18);
      check("press_change_hi", {31'd0, sif.o_change}, 32'd1);
      @(posedge clk);
      #1;
      check("press_change_lo", {31'd0, sif.o_change}, 32'd0);
      idle(2);
      check("press_pulses", chg_cnt, 1);
      sif.i_switch_1_raw = 1'b0;
      s = cyc + 1;
      wait_sel(2'b00, 40, e);
      check("release_edge", e, s + 18);
      idle(5);

      // Bounce on switch 2: toggle every 5 cycles for 40 cycles, then settle high.
      chg_cnt = 0;
      for (int k = 0; k < 8; k++) begin
         sif.i_switch_2_raw = (k % 2 == 0);
         idle(5);
      end
      check("bounce_no_pulse", chg_cnt, 0);
      sif.i_switch_2_raw = 1'b1;
      s = cyc + 1;
      wait_sel(2'b01, 40, e);
      check("bounce_settle_edge", e, s + 18);
      idle(3);
      check("bounce_pulses", chg_cnt, 1);
      sif.i_switch_2_raw = 1'b0;
      wait_sel(2'b00, 40, e);
      idle(5);

      // Glitches of 15 and 16 cycles must both be rejected.
      chg_cnt = 0;
      sif.i_switch_1_raw = 1'b1;
      idle(15);
      sif.i_switch_1_raw = 1'b0;
      idle(10);
      sif.i_switch_1_raw = 1'b1;
      idle(16);
      sif.i_switch_1_raw = 1'b0;
      idle(25);
      check("glitch_pulses", chg_cnt, 0);
      check("glitch_level", {31'd0, sif.o_switch_1}, 32'd0);

      // Simultaneous change on both channels.
      chg_cnt = 0;
      sif.i_switch_1_raw = 1'b1;
      sif.i_switch_2_raw = 1'b1;
      s = cyc + 1;
      wait_sel(2'b11, 40, e);
      check("both_rise_edge", e, s + 18);
      idle(3);
      check("both_rise_pulses", chg_cnt, 1);
      chg_cnt = 0;
      sif.i_switch_1_raw = 1'b0;
      sif.i_switch_2_raw = 1'b0;
      s = cyc + 1;
      wait_sel(2'b00, 40, e);
      check("both_fall_edge", e, s + 18);
      idle(3);
      check("both_fall_pulses", chg_cnt, 1);

      // Asynchronous reset with both outputs high.
      sif.i_switch_1_raw = 1'b1;
      sif.i_switch_2_raw = 1'b1;
      wait_sel(2'b11, 40, e);
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("async_reset", {27'd0, sif.o_switch_1, sif.o_switch_2, sif.o_select, sif.o_change},
            32'd0);
      idle(3);
      check("reset_held", {28'd0, sif.o_select, sif.o_change}, 32'd0);
      rst = 1'b0;
      s = cyc + 1;
      wait_sel(2'b11, 40, e);
      check("post_reset_rise", e, s + 18);

      // Reset in the middle of qualification discards progress.
      sif.i_switch_1_raw = 1'b0;
      sif.i_switch_2_raw = 1'b0;
      wait_sel(2'b00, 40, e);
      idle(3);
      sif.i_switch_1_raw = 1'b1;
      idle(10);
      @(posedge clk);
      #3;
      rst = 1'b1;
      idle(2);
      rst = 1'b0;
      s = cyc + 1;
      wait_sel(2'b10, 40, e);
      check("mid_qualify_rise", e, s + 18);
      idle(5);

      // Random phase: hold lengths straddle the qualification time; rare async resets.
      hold[0] = 0;
      hold[1] = 0;
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         if (hold[0] == 0) begin
            sif.i_switch_1_raw = ~sif.i_switch_1_raw;
            hold[0] = $urandom_range(1, 40);
         end else hold[0]--;
         if (hold[1] == 0) begin
            sif.i_switch_2_raw = ~sif.i_switch_2_raw;
            hold[1] = $urandom_range(1, 40);
         end else hold[1]--;
         if ($urandom_range(0, 799) == 0) begin
            #1 rst = 1'b1;
            #2 rst = 1'b0;
         end
      end
      idle(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/switch_debounce.md
Name: switch_debounce

Overview:
- Conditions the two raw front-panel mode switches before they reach the power-LED blink-rate selector.
- Per switch: 2-flop synchronizer, then a debounce counter/state machine.
- Drives clean, glitch-free levels straight onto the selector's i_switch_1/i_switch_2 inputs.
- Adds a one-cycle change strobe for any logic that must react to a mode change.

Parameters:
c_DEBOUNCE_CNT, 1108422, cycles a synchronized input must hold a new level before it is accepted (10 ms at 110.84 MHz); legal range 1..2^c_CNT_WIDTH-1
c_CNT_WIDTH, 21, width of each debounce counter; must satisfy c_DEBOUNCE_CNT <= 2^c_CNT_WIDTH-1

Ports:
i_clock  input  1  system clock; all state on rising edge
i_reset  input  1  asynchronous, active-high reset
i_switch_1_raw  input  1  raw switch 1 from pad, asynchronous, bouncy
i_switch_2_raw  input  1  raw switch 2 from pad, asynchronous, bouncy
o_switch_1  output  1  debounced switch 1 level (feeds selector i_switch_1)
o_switch_2  output  1  debounced switch 2 level (feeds selector i_switch_2)
o_select  output  2  {o_switch_1, o_switch_2}, same timing
o_change  output  1  one-cycle pulse on any debounced level change

Behaviour:
- Reset (asynchronous, active-high): all sync flops, counters, states, o_switch_1, o_switch_2 and o_change clear to 0 immediately. o_select = 2'b00 (100 Hz selection) until inputs qualify. Reset mid-debounce discards progress; no pulse is emitted.
- Synchronizer: two flops per channel, no reset-release glitch. Only the second-stage output (sync) feeds the state machine.
- Per-channel FSM, two states:
  - STABLE: counter held at 0. If sync != debounced level: go to CHANGING, counter = 0.
  - CHANGING, sync == debounced level: bounce rejected. Go to STABLE, counter = 0, no output change.
  - CHANGING, sync != level and counter == c_DEBOUNCE_CNT-1: debounced level <= sync, go to STABLE, counter = 0.
  - CHANGING, otherwise: counter += 1.
- Latency: raw level first sampled at edge S.
  - sync holds the new value after S+1.
  - FSM enters CHANGING at S+2.
  - Output updates at edge S+2+c_DEBOUNCE_CNT, if the input held throughout.
  - Glitches of c_DEBOUNCE_CNT cycles or fewer (as seen at sync) never reach the output.
- Counter never wraps: the terminal compare forces a return to STABLE.
- Any input flip during CHANGING restarts qualification from zero.
- o_change:
  - Registered, asserted for exactly the cycle after the edge at which either debounced level changes.
  - Both channels changing on the same edge give one pulse, not two.
  - Back-to-back qualified changes on different cycles give separate pulses.
- Outputs are registered, with no combinational path from raw inputs. o_select updates both bits on the same edge as the individual outputs.
- Both edges (0->1 and 1->0) are debounced identically.

Test Plan:
- Use c_DEBOUNCE_CNT=16 for all scenarios.
- Reset: assert i_reset asynchronously with raw inputs = 1 -> o_switch_1/2, o_select, o_change go 0 before the next clock edge; they stay 0 while reset is held.
- Clean press: i_switch_1_raw 0->1, first sampled at edge S -> o_switch_1 = 1 and o_select = 2'b10 at edge S+18; o_change high for exactly one cycle.
- Bounce: i_switch_2_raw toggles every 5 cycles for 40 cycles, then settles at 1 (final settle sampled at edge F) -> o_switch_2 stays 0 until edge F+18, then rises with one o_change pulse.
- Glitch rejection: 15-cycle high pulse, then 16-cycle high pulse, on i_switch_1_raw -> o_switch_1 stays 0 and o_change never asserts.
- Simultaneous: both raw inputs 0->1 on the same cycle -> o_select goes 2'b00->2'b11 on one edge with a single one-cycle o_change. Then both 1->0 -> o_select 2'b00 after 18 edges, one pulse.
- Reset mid-qualify: raw 1 held, i_reset pulsed 10 cycles after sampling, then released with raw still 1 -> output rises 18 edges after the first post-reset sampling edge; there is no early rise.
